interboard_credit_tx: RTL and testbench
=======================================

INTERBOARD_CREDIT_TX -- requirements
Module: interboard_credit_tx

Interface
REQ-001 Parameter DATA_W, default 11: width of one interboard word.
REQ-002 Parameter CREDITS, default 16: receiver buffer slots granted at link-up.
REQ-003 Parameter CREDIT_W, default 5: credit counter width; it SHALL hold 0..CREDITS.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fifo_data  in  DATA_W  normal-mode FIFO q; valid the cycle after rdreq.
REQ-007 rdempty  in  1  send FIFO empty.
REQ-008 rdreq  out  1  send FIFO read request.
REQ-009 link_up  in  1  receiving board present and ready, already synchronized to clk.
REQ-010 credit_return  in  1  one-cycle pulse; each pulse frees one receiver slot; already synchronized.
REQ-011 valid  out  1  send_data carries a new word this cycle.
REQ-012 send_data  out  DATA_W  word to the receiving board.
REQ-013 credits  out  CREDIT_W  current credit count.
REQ-014 credit_overflow  out  1  sticky error flag: credit returned while at CREDITS.

Function
REQ-015 States SHALL be LINK_DOWN, ACTIVE and DRAIN.
REQ-016 In LINK_DOWN: rdreq=0, credits=CREDITS, credit_return ignored; link_up=1 -> ACTIVE next cycle.
REQ-017 In ACTIVE: rdreq = !rdempty && credits!=0, combinational from registered state/credits and rdempty.
REQ-018 A word is in flight from its rdreq cycle until its valid cycle; DRAIN lasts until no word is in flight.
REQ-019 In ACTIVE, link_up=0 -> DRAIN; DRAIN SHALL issue no rdreq, complete every in-flight word, then -> LINK_DOWN.
REQ-020 In DRAIN, after the last in-flight word is sent: credits reload to CREDITS, state -> LINK_DOWN.
REQ-021 Latency: rdreq in cycle n -> fifo_data captured at end of n+1 -> valid=1 with send_data in cycle n+2.
REQ-022 Back-to-back rdreq SHALL yield back-to-back valid; valid is high exactly one cycle per rdreq.
REQ-023 send_data SHALL hold its last value while valid=0.
REQ-024 Credit update: next = credits - rdreq + credit_return, applied in ACTIVE and DRAIN.
REQ-025 rdreq and credit_return in the same cycle: credits unchanged.
REQ-026 credits==0: rdreq blocked; a credit_return there permits rdreq from the next cycle only, with no combinational bypass.
REQ-027 credit_return with credits==CREDITS and no rdreq: credits saturate at CREDITS, credit_overflow set.
REQ-028 credit_overflow SHALL stay set until reset.
REQ-029 rdempty rising while a word is in flight SHALL NOT cancel that word.

Reset
REQ-030 reset=1 at an edge: state=LINK_DOWN, rdreq=0, valid=0, send_data=0, credits=CREDITS, credit_overflow=0, in-flight tracking cleared.
REQ-031 Reset mid-transfer SHALL discard in-flight words; no valid is issued for them after reset.
REQ-032 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-033 DATA_W, CREDITS, CREDIT_W defaults and the state enum SHALL live in shared package interboard_pkg, also used by the receiver.
REQ-034 One sub-module, interboard_credit_counter: the saturating up/down counter plus the overflow flag.

Verification
REQ-035 Reset 5 cycles, link_up=1, FIFO non-empty with fifo_data=17 -> rdreq from the first ACTIVE cycle; valid two cycles later with send_data=17; credits decrement by 1 per word.
REQ-036 No credit_return, FIFO never empty -> exactly 16 valid words, then rdreq=0 and credits=0; one credit_return pulse -> rdreq exactly one cycle after the pulse, one more word sent.
REQ-037 credits=3, rdreq and credit_return in the same cycle -> credits stay 3; credit_return with credits=16 and no rdreq -> credits=16, credit_overflow=1 until reset.
REQ-038 link_up drops with 2 words in flight -> both words sent on valid, no further rdreq, credits=16 in LINK_DOWN.
REQ-039 reset asserted with 1 word in flight -> valid=0 on the next cycle, all outputs at reset values.
REQ-040 rdempty toggles every cycle -> rdreq only in non-empty cycles; valid count equals rdreq count.

Source files
------------

// File: rtl/interboard_pkg.sv
// Shared interboard link definitions used by both transmitter and receiver.
// Holds default link geometry and the link state encoding.
package interboard_pkg;

  localparam int DATA_W_DEF   = 11;
  localparam int CREDITS_DEF  = 16;
  localparam int CREDIT_W_DEF = 5;

  localparam logic [1:0] ST_LINK_DOWN = 2'd0;
  localparam logic [1:0] ST_ACTIVE    = 2'd1;
  localparam logic [1:0] ST_DRAIN     = 2'd2;

  typedef enum logic [1:0] {
    LINK_DOWN = ST_LINK_DOWN,
    ACTIVE    = ST_ACTIVE,
    DRAIN     = ST_DRAIN
  } link_state_e;

endpackage

// File: rtl/interboard_credit_counter.sv
// Saturating credit counter with sticky overflow flag; updates take effect next cycle.
// A return at full credit saturates and raises overflow until reset.
module interboard_credit_counter
  import interboard_pkg::*;
#(
  parameter int CREDITS  = CREDITS_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic                dec,
  input  logic                inc,
  output logic [CREDIT_W-1:0] count,
  output logic                overflow
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(CREDITS);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else if (load) begin
      count <= FULL;
    end else if (en) begin
      // simultaneous spend and return cancel out
      if (dec && !inc) begin
        if (count != '0) count <= count - ONE;
      end else if (inc && !dec) begin
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/interboard_credit_tx.sv
// Credit-based interboard transmitter: rdreq in cycle n gives valid/send_data in n+2.
// Reads stall when credits hit zero or FIFO is empty; link drop drains in-flight words first.
module interboard_credit_tx
  import interboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CREDITS  = CREDITS_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   fifo_data,
  input  logic                rdempty,
  output logic                rdreq,
  input  logic                link_up,
  input  logic                credit_return,
  output logic                valid,
  output logic [DATA_W-1:0]   send_data,
  output logic [CREDIT_W-1:0] credits,
  output logic                credit_overflow
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       word_pend;
  logic       drain_done;

  // word_pend marks a word whose FIFO data arrives this cycle
  assign rdreq      = !reset && (state == ST_ACTIVE) && !rdempty && (credits != '0);
  assign drain_done = (state == ST_DRAIN) && !word_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LINK_DOWN: if (link_up)   state_nxt = ST_ACTIVE;
      ST_ACTIVE:    if (!link_up)  state_nxt = ST_DRAIN;
      ST_DRAIN:     if (!word_pend) state_nxt = ST_LINK_DOWN;
      default:      state_nxt = ST_LINK_DOWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LINK_DOWN;
      word_pend <= 1'b0;
      valid     <= 1'b0;
      send_data <= '0;
    end else begin
      state     <= state_nxt;
      word_pend <= rdreq;
      valid     <= word_pend;
      if (word_pend) send_data <= fifo_data;
    end
  end

  interboard_credit_counter #(
    .CREDITS  (CREDITS),
    .CREDIT_W (CREDIT_W)
  ) u_credit_counter (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_LINK_DOWN) || drain_done),
    .en       (state != ST_LINK_DOWN),
    .dec      (rdreq),
    .inc      (credit_return),
    .count    (credits),
    .overflow (credit_overflow)
  );

endmodule

// File: tb/tb_interboard_credit_tx.sv
// Randomized and directed bench for interboard_credit_tx against a cycle-indexed word model.
module tb_interboard_credit_tx;

  localparam int DW   = 11;
  localparam int C    = 16;
  localparam int CW   = 5;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset, rdempty, link_up, credit_return;
  logic [DW-1:0] fifo_data;
  logic          rdreq, valid, credit_overflow;
  logic [DW-1:0] send_data;
  logic [CW-1:0] credits;

  always #5 clk = ~clk;

  interboard_credit_tx #(.DATA_W(DW), .CREDITS(C), .CREDIT_W(CW)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .rdempty(rdempty), .rdreq(rdreq),
    .link_up(link_up), .credit_return(credit_return), .valid(valid), .send_data(send_data),
    .credits(credits), .credit_overflow(credit_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model: link mode 0=down 1=active 2=drain; a word issued at cycle k is seen at k+2
  int            mode = 0;
  int            m_cred = C;
  bit            m_ovf = 1'b0;
  bit            known = 1'b0;
  bit            issued [MAXC];
  logic [DW-1:0] m_sd = '0;

  int rd_cnt = 0, vld_cnt = 0;
  logic          obs_rdreq, obs_valid, obs_ovf;
  logic [CW-1:0] obs_cred;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit word_outstanding(input int c);
    bit p = 1'b0;
    for (int k = c - 1; k <= c; k++)
      if (k >= 0 && issued[k] && (k + 2 > c)) p = 1'b1;
    return p;
  endfunction

  function automatic void apply_credit(input bit spend, input bit ret);
    if (spend && !ret) m_cred--;
    else if (ret && !spend) begin
      if (m_cred == C) m_ovf = 1'b1;
      else             m_cred++;
    end
  endfunction

  task automatic step(input bit r, input bit lu, input bit emp, input bit cr, input logic [DW-1:0] d);
    bit exp_rd, exp_vld;
    @(negedge clk);
    reset = r; link_up = lu; rdempty = emp; credit_return = cr; fifo_data = d;
    #1;
    exp_rd  = !r && (mode == 1) && !emp && (m_cred != 0);
    exp_vld = (cyc >= 2) && issued[cyc-2];
    obs_rdreq = rdreq; obs_valid = valid; obs_cred = credits; obs_ovf = credit_overflow;
    if (known) begin
      chk("rdreq", 32'(rdreq), 32'(exp_rd));
      chk("valid", 32'(valid), 32'(exp_vld));
      chk("send_data", 32'(send_data), 32'(m_sd));
      chk("credits", 32'(credits), 32'(m_cred));
      chk("overflow", 32'(credit_overflow), 32'(m_ovf));
    end
    if (rdreq) rd_cnt++;
    if (valid) vld_cnt++;
    @(posedge clk);
    issued[cyc] = exp_rd;
    if (r) begin
      mode = 0; m_cred = C; m_ovf = 1'b0; m_sd = '0; known = 1'b1;
      issued[cyc] = 1'b0;
      if (cyc >= 1) issued[cyc-1] = 1'b0;
    end else begin
      if (cyc >= 1 && issued[cyc-1]) m_sd = d;
      case (mode)
        0: if (lu) mode = 1;
        1: begin
          apply_credit(exp_rd, cr);
          if (!lu) mode = 2;
        end
        default: begin
          if (!word_outstanding(cyc)) begin
            m_cred = C; mode = 0;
          end else apply_credit(1'b0, cr);
        end
      endcase
    end
    cyc++;
  endtask

  int v0, r0;

  initial begin
    reset = 1'b1; link_up = 1'b0; rdempty = 1'b1; credit_return = 1'b0; fifo_data = '0;

    // bring-up with constant data 17 and a never-empty FIFO
    repeat (5) step(1, 1, 0, 0, 11'd17);
    v0 = vld_cnt;
    repeat (24) step(0, 1, 0, 0, 11'd17);
    chk("p1_words", 32'(vld_cnt - v0), 32'd16);
    chk("p1_cred_zero", 32'(obs_cred), 32'd0);
    chk("p1_stalled", 32'(obs_rdreq), 32'd0);
    step(0, 1, 0, 1, 11'd17);
    chk("p1_no_bypass", 32'(obs_rdreq), 32'd0);
    step(0, 1, 0, 0, 11'd17);
    chk("p1_resume", 32'(obs_rdreq), 32'd1);
    repeat (4) step(0, 1, 0, 0, 11'd17);
    chk("p1_one_more", 32'(vld_cnt - v0), 32'd17);

    // overflow at full credit, sticky until reset
    repeat (2) step(1, 1, 1, 0, '0);
    repeat (2) step(0, 1, 1, 0, '0);
    step(0, 1, 1, 1, '0);
    repeat (3) step(0, 1, 1, 0, '0);
    chk("p2_ovf_sticky", 32'(obs_ovf), 32'd1);
    chk("p2_cred_full", 32'(obs_cred), 32'(C));
    step(1, 1, 1, 0, '0);
    step(0, 1, 1, 0, '0);
    chk("p2_ovf_cleared", 32'(obs_ovf), 32'd0);

    // simultaneous spend and return at credits=3
    repeat (2) step(1, 1, 1, 0, '0);
    repeat (2) step(0, 1, 1, 0, '0);
    for (int i = 0; i < 40 && m_cred != 3; i++) step(0, 1, 0, 0, DW'($urandom));
    step(0, 1, 0, 1, DW'($urandom));
    chk("p3_both_rd", 32'(obs_rdreq), 32'd1);
    step(0, 1, 1, 0, '0);
    chk("p3_cred_held", 32'(obs_cred), 32'd3);

    // link drop with two words in flight
    repeat (2) step(1, 1, 1, 0, '0);
    repeat (2) step(0, 1, 1, 0, '0);
    v0 = vld_cnt; r0 = rd_cnt;
    step(0, 1, 0, 0, 11'h2a5);
    step(0, 0, 0, 0, 11'h15a);
    repeat (6) step(0, 0, 0, 0, DW'($urandom));
    chk("p4_rd", 32'(rd_cnt - r0), 32'd2);
    chk("p4_vld", 32'(vld_cnt - v0), 32'd2);
    chk("p4_cred", 32'(obs_cred), 32'(C));

    // reset with one word in flight
    repeat (2) step(1, 1, 1, 0, '0);
    repeat (2) step(0, 1, 1, 0, '0);
    step(0, 1, 0, 0, 11'h3ff);
    v0 = vld_cnt;
    step(1, 1, 0, 0, 11'h3ff);
    repeat (3) step(0, 0, 1, 0, 11'h3ff);
    chk("p5_discard", 32'(vld_cnt - v0), 32'd0);

    // rdempty toggling every cycle
    repeat (2) step(1, 1, 1, 0, '0);
    repeat (2) step(0, 1, 1, 0, '0);
    v0 = vld_cnt; r0 = rd_cnt;
    for (int i = 0; i < 40; i++) step(0, 1, i[0], (i % 3) == 0, DW'($urandom));
    repeat (3) step(0, 1, 1, 0, '0);
    chk("p6_rd_eq_vld", 32'(rd_cnt - r0), 32'(vld_cnt - v0));

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, DW'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
